// File: rtl/pv_interneuron_bank.sv
// pv_interneuron_bank
// Bank of PV+ basket-cell inhibition units placed between the L2/3 oscillator
// outputs and the L2/3 inhibitory input. Each clk_en strobe starts a sweep that
// processes one channel per clock. For each channel the unit:
//   - estimates the oscillator amplitude as max(|x|,|y|) + min(|x|,|y|)/2,
//   - leaks it into a first-order envelope,
//   - thresholds that envelope, scales it by gain (Q4.14) and saturates the
//     result into a non-negative inhibition current.
//
// Optional feature: define PV_GAP_JUNCTION_EN to add ring-topology gap-junction
// coupling between neighbouring envelopes. The coupling uses a snapshot of all
// envelopes taken at sweep start (env_prev), so the result does not depend on
// sweep order.
//
// Ports:
//   clk        clock
//   rst        synchronous, active-high reset
//   clk_en     update strobe; starts a sweep when idle
//   l23_x_bus  per-channel L2/3 x, channel k at [k*WIDTH +: WIDTH]
//   l23_y_bus  per-channel L2/3 y
//   threshold  envelope threshold (negative treated as 0)
//   gain       inhibition gain, Q4.14 (negative treated as 0)
//   inhib_bus  per-channel inhibition, always >= 0
//   env_bus    per-channel envelope, always >= 0
//   busy       sweep in progress
//   done       one-cycle pulse after the last channel is written
//   overrun    sticky: a strobe arrived while busy or done; cleared by rst
module pv_interneuron_bank #(
  parameter int WIDTH     = 18,
  parameter int FRAC      = 14,
  parameter int NCH       = 4,
  parameter int TAU_SHIFT = 3,
  parameter int GJ_SHIFT  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clk_en,
  input  logic [NCH*WIDTH-1:0] l23_x_bus,
  input  logic [NCH*WIDTH-1:0] l23_y_bus,
  input  logic [WIDTH-1:0]     threshold,
  input  logic [WIDTH-1:0]     gain,
  output logic [NCH*WIDTH-1:0] inhib_bus,
  output logic [NCH*WIDTH-1:0] env_bus,
  output logic                 busy,
  output logic                 done,
  output logic                 overrun
);

  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;
  // Envelope plus coupling needs headroom: a Laplacian of non-negative values
  // spans +-2*max, so three guard bits cover the sum before clamping.
  localparam int EW = WIDTH + 3;
  localparam logic [WIDTH-1:0] POS_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] NEG_MIN = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CHW-1:0]   CH_LAST = CHW'(NCH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t         state_r, state_s;
  logic [CHW-1:0] ch_r, ch_s;

  logic [WIDTH-1:0]        x_s, y_s, env_cur_s, amp_s;
  logic signed [WIDTH:0]   diff_s, env_lp_s;
  logic signed [EW-1:0]    coup_s, env_ext_s;
  logic [WIDTH-1:0]        env_new_s, thr_c_s, gain_c_s, d_pos_s, inhib_new_s;
  logic signed [WIDTH:0]   d_s;
  logic signed [2*WIDTH-1:0] prod_s, prod_sh_s;

`ifdef PV_GAP_JUNCTION_EN
  logic [WIDTH-1:0]     env_prev_r [NCH];
  logic [CHW-1:0]       chm_s, chp_s;
  logic signed [EW-1:0] lap_s;
`endif

  // Magnitude of a signed sample; the most negative code saturates.
  function automatic logic [WIDTH-1:0] abs_sat(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] r;
    if (v == NEG_MIN) begin
      r = POS_MAX;
    end else if (v[WIDTH-1]) begin
      r = ~v + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      r = v;
    end
    return r;
  endfunction

  // Alpha-max-plus-beta-min amplitude estimate (alpha=1, beta=1/2), saturated.
  function automatic logic [WIDTH-1:0] amp_est(input logic [WIDTH-1:0] ax,
                                               input logic [WIDTH-1:0] ay);
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] r;
    if (ax >= ay) begin
      hi = ax;
      lo = ay;
    end else begin
      hi = ay;
      lo = ax;
    end
    sum = {1'b0, hi} + ({1'b0, lo} >> 1);
    if (sum > {1'b0, POS_MAX}) begin
      r = POS_MAX;
    end else begin
      r = sum[WIDTH-1:0];
    end
    return r;
  endfunction

  // Clamp an extended signed value into [0, POS_MAX].
  function automatic logic [WIDTH-1:0] clamp_nonneg(input logic signed [EW-1:0] v);
    logic [WIDTH-1:0] r;
    if (v[EW-1]) begin
      r = {WIDTH{1'b0}};
    end else if (v > $signed({{(EW-WIDTH){1'b0}}, POS_MAX})) begin
      r = POS_MAX;
    end else begin
      r = v[WIDTH-1:0];
    end
    return r;
  endfunction

  // FSM next-state: idle -> sweep all channels -> one done cycle -> idle.
  always_comb begin
    state_s = state_r;
    ch_s    = ch_r;
    case (state_r)
      IDLE: begin
        if (clk_en) begin
          state_s = SWEEP;
          ch_s    = {CHW{1'b0}};
        end else begin
          state_s = IDLE;
        end
      end
      SWEEP: begin
        if (ch_r == CH_LAST) begin
          state_s = DONE;
        end else begin
          ch_s = ch_r + {{(CHW-1){1'b0}}, 1'b1};
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
        ch_s    = {CHW{1'b0}};
      end
    endcase
  end

  // Per-channel datapath for the channel currently selected by ch_r.
  always_comb begin
    x_s       = l23_x_bus[int'(ch_r)*WIDTH +: WIDTH];
    y_s       = l23_y_bus[int'(ch_r)*WIDTH +: WIDTH];
    env_cur_s = env_bus[int'(ch_r)*WIDTH +: WIDTH];
    amp_s     = amp_est(abs_sat(x_s), abs_sat(y_s));

    // Stored envelopes are never negative, so zero-extension is exact.
    diff_s   = $signed({1'b0, amp_s}) - $signed({1'b0, env_cur_s});
    env_lp_s = $signed({1'b0, env_cur_s}) + (diff_s >>> TAU_SHIFT);

`ifdef PV_GAP_JUNCTION_EN
    if (ch_r == {CHW{1'b0}}) begin
      chm_s = CH_LAST;
    end else begin
      chm_s = ch_r - {{(CHW-1){1'b0}}, 1'b1};
    end
    if (ch_r == CH_LAST) begin
      chp_s = {CHW{1'b0}};
    end else begin
      chp_s = ch_r + {{(CHW-1){1'b0}}, 1'b1};
    end
    lap_s = $signed({{(EW-WIDTH){1'b0}}, env_prev_r[chm_s]})
          + $signed({{(EW-WIDTH){1'b0}}, env_prev_r[chp_s]})
          - $signed({{(EW-WIDTH-1){1'b0}}, env_prev_r[ch_r], 1'b0});
    coup_s = lap_s >>> GJ_SHIFT;
`else
    coup_s = {EW{1'b0}};
`endif

    env_ext_s = $signed({{(EW-WIDTH-1){env_lp_s[WIDTH]}}, env_lp_s}) + coup_s;
    env_new_s = clamp_nonneg(env_ext_s);

    if (threshold[WIDTH-1]) begin
      thr_c_s = {WIDTH{1'b0}};
    end else begin
      thr_c_s = threshold;
    end
    if (gain[WIDTH-1]) begin
      gain_c_s = {WIDTH{1'b0}};
    end else begin
      gain_c_s = gain;
    end

    d_s = $signed({1'b0, env_new_s}) - $signed({1'b0, thr_c_s});
    if (d_s[WIDTH]) begin
      d_pos_s = {WIDTH{1'b0}};
    end else begin
      d_pos_s = d_s[WIDTH-1:0];
    end

    prod_s    = $signed({{WIDTH{1'b0}}, d_pos_s}) * $signed({{WIDTH{1'b0}}, gain_c_s});
    prod_sh_s = prod_s >>> FRAC;
    if (prod_sh_s > $signed({{WIDTH{1'b0}}, POS_MAX})) begin
      inhib_new_s = POS_MAX;
    end else begin
      inhib_new_s = prod_sh_s[WIDTH-1:0];
    end
  end

  // FSM state, channel index and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      ch_r    <= {CHW{1'b0}};
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_r <= state_s;
      ch_r    <= ch_s;
      busy    <= (state_s == SWEEP);
      done    <= (state_s == DONE);
    end
  end

  // Sticky overrun: any strobe outside IDLE is dropped and flagged.
  always_ff @(posedge clk) begin
    if (rst) begin
      overrun <= 1'b0;
    end else if (clk_en && (state_r != IDLE)) begin
      overrun <= 1'b1;
    end else begin
      overrun <= overrun;
    end
  end

  // Envelope and inhibition registers; only the swept channel is written.
  always_ff @(posedge clk) begin
    if (rst) begin
      env_bus   <= {(NCH*WIDTH){1'b0}};
      inhib_bus <= {(NCH*WIDTH){1'b0}};
    end else if (state_r == SWEEP) begin
      env_bus[int'(ch_r)*WIDTH +: WIDTH]   <= env_new_s;
      inhib_bus[int'(ch_r)*WIDTH +: WIDTH] <= inhib_new_s;
    end else begin
      env_bus   <= env_bus;
      inhib_bus <= inhib_bus;
    end
  end

`ifdef PV_GAP_JUNCTION_EN
  // Snapshot all envelopes at sweep start for order-independent coupling.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NCH; k++) begin
        env_prev_r[k] <= {WIDTH{1'b0}};
      end
    end else if ((state_r == IDLE) && clk_en) begin
      for (int k = 0; k < NCH; k++) begin
        env_prev_r[k] <= env_bus[k*WIDTH +: WIDTH];
      end
    end else begin
      for (int k = 0; k < NCH; k++) begin
        env_prev_r[k] <= env_prev_r[k];
      end
    end
  end
`endif

endmodule

// File: tb/tb_pv_interneuron_bank.sv
// Self-checking bench for pv_interneuron_bank. A behavioural model in plain
// integer arithmetic tracks per-channel envelope and inhibition for each sweep.
module tb_pv_interneuron_bank;

  localparam int WIDTH     = 18;
  localparam int FRAC      = 14;
  localparam int NCH       = 4;
  localparam int TAU_SHIFT = 3;
  localparam int GJ_SHIFT  = 2;
  localparam int MAXV      = (1 << (WIDTH - 1)) - 1;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 clk_en = 1'b0;
  logic [NCH*WIDTH-1:0] l23_x_bus = '0;
  logic [NCH*WIDTH-1:0] l23_y_bus = '0;
  logic [WIDTH-1:0]     threshold = '0;
  logic [WIDTH-1:0]     gain = '0;
  logic [NCH*WIDTH-1:0] inhib_bus;
  logic [NCH*WIDTH-1:0] env_bus;
  logic                 busy;
  logic                 done;
  logic                 overrun;

  pv_interneuron_bank #(
    .WIDTH(WIDTH), .FRAC(FRAC), .NCH(NCH), .TAU_SHIFT(TAU_SHIFT), .GJ_SHIFT(GJ_SHIFT)
  ) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en),
    .l23_x_bus(l23_x_bus), .l23_y_bus(l23_y_bus),
    .threshold(threshold), .gain(gain),
    .inhib_bus(inhib_bus), .env_bus(env_bus),
    .busy(busy), .done(done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int m_env[NCH];
  int m_inhib[NCH];
  int sx[NCH];
  int sy[NCH];
  int m_thr = 0;
  int m_gain = 0;

  function automatic int get_env(int k);
    logic signed [WIDTH-1:0] v;
    v = env_bus[k*WIDTH +: WIDTH];
    return int'(v);
  endfunction

  function automatic int get_inhib(int k);
    logic signed [WIDTH-1:0] v;
    v = inhib_bus[k*WIDTH +: WIDTH];
    return int'(v);
  endfunction

  function automatic int get_in(logic [NCH*WIDTH-1:0] bus, int k);
    logic signed [WIDTH-1:0] v;
    v = bus[k*WIDTH +: WIDTH];
    return int'(v);
  endfunction

  task automatic set_ch(int k, int x, int y);
    l23_x_bus[k*WIDTH +: WIDTH] = WIDTH'(x);
    l23_y_bus[k*WIDTH +: WIDTH] = WIDTH'(y);
  endtask

  task automatic set_params(int thr, int gn);
    threshold = WIDTH'(thr);
    gain      = WIDTH'(gn);
    m_thr     = thr;
    m_gain    = gn;
  endtask

  function automatic int rand_sample();
    int r;
    case ($urandom_range(0, 5))
      0:       r = -(MAXV + 1);
      1:       r = MAXV;
      default: r = int'($urandom_range(0, 2 * MAXV + 1)) - (MAXV + 1);
    endcase
    return r;
  endfunction

  function automatic int sat_abs(int v);
    int a;
    a = (v < 0) ? -v : v;
    return (a > MAXV) ? MAXV : a;
  endfunction

  // One sweep of the reference model from the recorded per-channel inputs.
  function automatic void model_sweep();
    int prev[NCH];
    int a, b, amp, e, t, g, d;
    longint p;
    prev = m_env;
    for (int k = 0; k < NCH; k++) begin
      a   = sat_abs(sx[k]);
      b   = sat_abs(sy[k]);
      amp = (a >= b) ? a + b / 2 : b + a / 2;
      if (amp > MAXV) amp = MAXV;
      e = prev[k] + ((amp - prev[k]) >>> TAU_SHIFT);
`ifdef PV_GAP_JUNCTION_EN
      e = e + ((prev[(k + NCH - 1) % NCH] + prev[(k + 1) % NCH] - 2 * prev[k]) >>> GJ_SHIFT);
`endif
      if (e < 0) e = 0;
      if (e > MAXV) e = MAXV;
      t = (m_thr < 0) ? 0 : m_thr;
      g = (m_gain < 0) ? 0 : m_gain;
      d = e - t;
      if (d < 0) d = 0;
      p = (longint'(d) * longint'(g)) >>> FRAC;
      if (p > MAXV) p = MAXV;
      m_env[k]   = e;
      m_inhib[k] = int'(p);
    end
  endfunction

  task automatic reset_dut();
    @(negedge clk);
    rst    = 1'b1;
    clk_en = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      m_env[k]   = 0;
      m_inhib[k] = 0;
    end
  endtask

  // Called at a negedge with the DUT idle; returns at the first negedge where
  // a new strobe is legal. Inputs seen at channel k's cycle are recorded.
  task automatic run_sweep(input bit vary);
    clk_en = 1'b1;
    @(negedge clk);
    clk_en = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      if (vary) begin
        for (int j = 0; j < NCH; j++) set_ch(j, rand_sample(), rand_sample());
      end
      sx[k] = get_in(l23_x_bus, k);
      sy[k] = get_in(l23_y_bus, k);
      @(negedge clk);
    end
    @(negedge clk);
    model_sweep();
  endtask

  task automatic test_reset();
    l23_x_bus = '0;
    l23_y_bus = '0;
    set_params(0, 0);
    reset_dut();
    n_checks++; if (env_bus !== '0) begin n_fail++; $display("FAIL reset_env: got %h expected 0", env_bus); end
    n_checks++; if (inhib_bus !== '0) begin n_fail++; $display("FAIL reset_inhib: got %h expected 0", inhib_bus); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
    clk_en = 1'b1;
    @(negedge clk);
    clk_en = 1'b0;
    for (int i = 0; i < NCH + 2; i++) begin
      n_checks++;
      if (busy !== (i < NCH)) begin n_fail++; $display("FAIL busy_timing c%0d: got %b expected %b", i, busy, (i < NCH)); end
      n_checks++;
      if (done !== (i == NCH)) begin n_fail++; $display("FAIL done_timing c%0d: got %b expected %b", i, done, (i == NCH)); end
      @(negedge clk);
    end
  endtask

  task automatic test_envelope();
    reset_dut();
    l23_x_bus = '0;
    l23_y_bus = '0;
    set_ch(0, 8192, 0);
    set_params(0, 16384);
    run_sweep(1'b0);
    n_checks++; if (get_env(0) !== 1024) begin n_fail++; $display("FAIL env0_first: got %0d expected 1024", get_env(0)); end
    n_checks++; if (get_inhib(0) !== 1024) begin n_fail++; $display("FAIL inhib0_first: got %0d expected 1024", get_inhib(0)); end
    for (int s = 1; s < 64; s++) begin
      run_sweep(1'b0);
      for (int k = 0; k < NCH; k++) begin
        n_checks++; if (get_env(k) !== m_env[k]) begin n_fail++; $display("FAIL conv_env s%0d ch%0d: got %0d expected %0d", s, k, get_env(k), m_env[k]); end
        n_checks++; if (get_inhib(k) !== m_inhib[k]) begin n_fail++; $display("FAIL conv_inhib s%0d ch%0d: got %0d expected %0d", s, k, get_inhib(k), m_inhib[k]); end
      end
    end
`ifndef PV_GAP_JUNCTION_EN
    n_checks++;
    if ((get_env(0) < 8192 - 8) || (get_env(0) > 8192 + 8)) begin
      n_fail++; $display("FAIL env0_converged: got %0d expected 8192+-8", get_env(0));
    end
    for (int k = 1; k < NCH; k++) begin
      n_checks++; if (get_env(k) !== 0) begin n_fail++; $display("FAIL idle_env ch%0d: got %0d expected 0", k, get_env(k)); end
      n_checks++; if (get_inhib(k) !== 0) begin n_fail++; $display("FAIL idle_inhib ch%0d: got %0d expected 0", k, get_inhib(k)); end
    end
`endif
  endtask

  task automatic test_saturation_threshold();
    int prev_e, e1, exp_i;
    reset_dut();
    l23_x_bus = '0;
    l23_y_bus = '0;
    set_ch(1, -131072, -131072);
    set_params(20000, 16384);
    prev_e = 0;
    for (int s = 0; s < 30; s++) begin
      run_sweep(1'b0);
      e1 = get_env(1);
      if (s == 0) begin
        n_checks++; if (e1 !== 16383) begin n_fail++; $display("FAIL sat_env1_first: got %0d expected 16383", e1); end
      end
      n_checks++; if (e1 !== m_env[1]) begin n_fail++; $display("FAIL sat_env1 s%0d: got %0d expected %0d", s, e1, m_env[1]); end
      n_checks++; if ((e1 < 0) || (e1 > MAXV)) begin n_fail++; $display("FAIL sat_range s%0d: got %0d expected 0..%0d", s, e1, MAXV); end
`ifndef PV_GAP_JUNCTION_EN
      n_checks++; if (e1 < prev_e) begin n_fail++; $display("FAIL sat_monotonic s%0d: got %0d expected >= %0d", s, e1, prev_e); end
`endif
      exp_i = (e1 > 20000) ? e1 - 20000 : 0;
      n_checks++; if (get_inhib(1) !== exp_i) begin n_fail++; $display("FAIL thr_inhib1 s%0d: got %0d expected %0d", s, get_inhib(1), exp_i); end
      prev_e = e1;
    end
  endtask

  task automatic test_random();
    reset_dut();
    for (int s = 0; s < 20; s++) begin
      set_params(int'($urandom_range(0, 40000)) - 8000, int'($urandom_range(0, 70000)) - 4000);
      run_sweep(1'b1);
      for (int k = 0; k < NCH; k++) begin
        n_checks++; if (get_env(k) !== m_env[k]) begin n_fail++; $display("FAIL rand_env s%0d ch%0d: got %0d expected %0d", s, k, get_env(k), m_env[k]); end
        n_checks++; if (get_inhib(k) !== m_inhib[k]) begin n_fail++; $display("FAIL rand_inhib s%0d ch%0d: got %0d expected %0d", s, k, get_inhib(k), m_inhib[k]); end
      end
    end
  endtask

  task automatic test_overrun();
    l23_x_bus = '0;
    l23_y_bus = '0;
    set_params(0, 16384);
    reset_dut();
    clk_en = 1'b1;
    @(negedge clk);
    clk_en = 1'b0;
    @(negedge clk);
    clk_en = 1'b1;
    @(negedge clk);
    clk_en = 1'b0;
    n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL overrun_set: got %b expected 1", overrun); end
    for (int j = 3; j < NCH + 6; j++) begin
      n_checks++;
      if (busy !== (j <= NCH)) begin n_fail++; $display("FAIL ovr_busy c%0d: got %b expected %b", j, busy, (j <= NCH)); end
      n_checks++;
      if (done !== (j == NCH + 1)) begin n_fail++; $display("FAIL ovr_done c%0d: got %b expected %b", j, done, (j == NCH + 1)); end
      @(negedge clk);
    end
    run_sweep(1'b0);
    n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL overrun_sticky: got %b expected 1", overrun); end
    reset_dut();
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL overrun_clear: got %b expected 0", overrun); end
  endtask

  task automatic test_reset_mid_sweep();
    reset_dut();
    for (int k = 0; k < NCH; k++) set_ch(k, 8192, 0);
    set_params(0, 16384);
    run_sweep(1'b0);
    n_checks++; if (get_env(2) !== m_env[2]) begin n_fail++; $display("FAIL mid_pre_env2: got %0d expected %0d", get_env(2), m_env[2]); end
    clk_en = 1'b1;
    @(negedge clk);
    clk_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++; if (env_bus !== '0) begin n_fail++; $display("FAIL mid_env: got %h expected 0", env_bus); end
    n_checks++; if (inhib_bus !== '0) begin n_fail++; $display("FAIL mid_inhib: got %h expected 0", inhib_bus); end
    for (int i = 0; i < NCH + 3; i++) begin
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy c%0d: got %b expected 0", i, busy); end
      n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL mid_done c%0d: got %b expected 0", i, done); end
      @(negedge clk);
    end
    for (int k = 0; k < NCH; k++) begin
      m_env[k]   = 0;
      m_inhib[k] = 0;
    end
  endtask

  task automatic test_back_to_back();
    reset_dut();
    for (int k = 0; k < NCH; k++) set_ch(k, rand_sample(), rand_sample());
    set_params(int'($urandom_range(0, 5000)), int'($urandom_range(8000, 40000)));
    for (int s = 0; s < 5; s++) begin
      run_sweep(1'b0);
      for (int k = 0; k < NCH; k++) begin
        n_checks++; if (get_env(k) !== m_env[k]) begin n_fail++; $display("FAIL b2b_env s%0d ch%0d: got %0d expected %0d", s, k, get_env(k), m_env[k]); end
        n_checks++; if (get_inhib(k) !== m_inhib[k]) begin n_fail++; $display("FAIL b2b_inhib s%0d ch%0d: got %0d expected %0d", s, k, get_inhib(k), m_inhib[k]); end
      end
    end
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL b2b_overrun: got %b expected 0", overrun); end
  endtask

`ifdef PV_GAP_JUNCTION_EN
  task automatic test_gap_junction();
    reset_dut();
    l23_x_bus = '0;
    l23_y_bus = '0;
    set_ch(0, 8192, 0);
    set_params(0, 16384);
    run_sweep(1'b0);
    n_checks++; if (get_env(1) !== 0) begin n_fail++; $display("FAIL gj_env1_first: got %0d expected 0", get_env(1)); end
    run_sweep(1'b0);
    n_checks++; if (get_env(1) !== 256) begin n_fail++; $display("FAIL gj_env1: got %0d expected 256", get_env(1)); end
    n_checks++; if (get_env(3) !== 256) begin n_fail++; $display("FAIL gj_env3: got %0d expected 256", get_env(3)); end
    n_checks++; if (!(get_inhib(1) > 0)) begin n_fail++; $display("FAIL gj_inhib1: got %0d expected > 0", get_inhib(1)); end
    for (int s = 0; s < 10; s++) begin
      run_sweep(1'b0);
      for (int k = 0; k < NCH; k++) begin
        n_checks++; if (get_env(k) !== m_env[k]) begin n_fail++; $display("FAIL gj_env s%0d ch%0d: got %0d expected %0d", s, k, get_env(k), m_env[k]); end
        n_checks++; if (get_inhib(k) !== m_inhib[k]) begin n_fail++; $display("FAIL gj_inhib s%0d ch%0d: got %0d expected %0d", s, k, get_inhib(k), m_inhib[k]); end
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_envelope();
    test_saturation_threshold();
    test_random();
    test_overrun();
    test_reset_mid_sweep();
    test_back_to_back();
`ifdef PV_GAP_JUNCTION_EN
    test_gap_junction();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/pv_interneuron_bank.md
# pv_interneuron_bank

Parametrised bank of PV+ basket-cell inhibition units, successor to the single minimal PV+ path inside the cortical column. For each of NCH channels it estimates L2/3 oscillator amplitude, low-pass filters it into an envelope, and produces a thresholded, gain-scaled, saturated inhibition current. The bank sits between the L2/3 oscillator outputs and the L2/3 inhibitory input. Channels are processed one per clock in a sweep triggered by each clk_en update strobe.

## Interface
- WIDTH, 18, signed sample width
- FRAC, 14, fractional bits (Q4.14)
- NCH, 4, channel count (2..64)
- TAU_SHIFT, 3, envelope leak shift (1..8)
- GJ_SHIFT, 2, gap-junction coupling shift (used only with PV_GAP_JUNCTION_EN)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- clk_en  in  1  update strobe; starts a sweep
- l23_x_bus  in  NCH*WIDTH  per-channel L2/3 x; channel k occupies bits [k*WIDTH +: WIDTH]
- l23_y_bus  in  NCH*WIDTH  per-channel L2/3 y
- threshold  in  WIDTH  envelope threshold; values below 0 are treated as 0
- gain  in  WIDTH  inhibition gain, Q4.14; values below 0 are treated as 0
- inhib_bus  out  NCH*WIDTH  per-channel inhibition, always >= 0
- env_bus  out  NCH*WIDTH  per-channel envelope
- busy  out  1  sweep in progress
- done  out  1  one-cycle pulse at sweep completion
- overrun  out  1  sticky flag: clk_en arrived while busy

## Operation
- FSM states:
  - IDLE: on clk_en, go to SWEEP and set ch=0. At the same edge, snapshot env into env_prev (NCH registers).
  - SWEEP: process channel ch. If ch==NCH-1, go to DONE; otherwise ch+1.
  - DONE: assert done, then return to IDLE.
- Amplitude:
  - ax=|x|, ay=|y|. Taking |-2^(WIDTH-1)| saturates to 2^(WIDTH-1)-1.
  - amp = max(ax,ay) + (min(ax,ay)>>>1), saturated to 2^(WIDTH-1)-1.
- Envelope: env_new = env + ((amp - env) >>> TAU_SHIFT), computed in WIDTH+1 bits. The result is always >= 0.
- Inhibition:
  - d = max(env_new - threshold, 0)
  - inhib = (d*gain) >>> FRAC, computed in 2*WIDTH bits and saturated to 2^(WIDTH-1)-1.
- Channel ch's env and inhib registers update at the end of its SWEEP cycle. All other channels hold their values.
- clk_en while busy or in DONE: ignored, no restart; overrun set to 1. It is cleared only by rst.
- clk_en in IDLE during the done cycle's successor starts a new sweep normally.
- Inputs are sampled during each channel's own SWEEP cycle, not at the strobe.

## Timing
- clk_en high at edge t puts the FSM in SWEEP from cycle t+1.
- Channel k is written at edge t+2+k.
- done is high for cycle t+1+NCH. busy is high for cycles t+1..t+NCH.
- Minimum strobe spacing without overrun: NCH+2 clocks.
- Reset values: state IDLE, ch=0; all env, env_prev, and inhib are 0; busy=0, done=0, overrun=0.
- rst mid-sweep: everything returns to reset values on the next edge. No done pulse is produced.

## Configuration
- PV_GAP_JUNCTION_EN defined: before thresholding, add coupling to env_new for channel k:
  - Coupling = (env_prev[k-1] + env_prev[k+1] - 2*env_prev[k]) >>> GJ_SHIFT. Neighbours wrap (ring).
  - The result is saturated to [0, 2^(WIDTH-1)-1].
  - env_prev is used, so the result is independent of sweep order.
- PV_GAP_JUNCTION_EN not defined: no coupling. env_prev is not built, and GJ_SHIFT is unused.

## Test plan
- Reset check: after reset, all outputs are 0. A clk_en puts busy high for exactly 4 cycles, followed by one done pulse.
- Envelope convergence:
  - Stimulus: NCH=4, ch0 x=8192 y=0, threshold=0, gain=16384.
  - After sweep 1, env0=1024 and inhib0=1024.
  - After 64 sweeps, env0 is within 8 LSB of 8192. Channels 1..3 stay 0.
- Amplitude saturation and threshold:
  - Saturation: ch1 x=-131072, y=-131072 gives amp=131071. env1 rises monotonically without wrap.
  - Threshold: threshold=20000 holds inhib1=0 until env1>20000.
- Overrun: a second clk_en 2 cycles after the first sets overrun=1. done still fires at t+5, with no restart. overrun stays set until rst.
- Reset mid-sweep: rst asserted at channel 2 clears all env and inhib on the next edge. busy=0 and no done pulse follows.
- Gap junction (PV_GAP_JUNCTION_EN on): drive only ch0 to env≈8192.
  - The next sweep gives env1 and env3 an increase of about 2048 above their no-coupling values, and inhib1 > 0.
  - With the macro off, env1 and env3 stay 0.
